// File: rtl/ak16_pkg.sv
// Shared constants and types for the ak16 load/store unit.
// State encoding, dmem range and the request capture bundle.
package ak16_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MEM_AW = 8;

  localparam logic [ADDR_W-1:0] FAULT_MASK =
    {{(ADDR_W-MEM_AW){1'b1}}, {MEM_AW{1'b0}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_CAP   = 3'd2;
  localparam logic [2:0] S_MERGE = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    RD    = S_RD,
    CAP   = S_CAP,
    MERGE = S_MERGE,
    WR    = S_WR,
    RESP  = S_RESP
  } lsu_state_t;

  typedef struct packed {
    logic       we;
    logic       byt;
    logic       hi;
    logic       sgn;
    logic [7:0] wbyte;
  } lsu_req_t;

  function automatic logic addr_fault(
    input logic [ADDR_W-1:0] a
  );
    return |(a & FAULT_MASK);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response handshake plus dmem bus for the lsu.
// slave = lsu side, master = pipeline and dmem side.
interface lsu_if;
  import ak16_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic              req_hi;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_fault;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_we,
    input  req_byte,
    input  req_hi,
    input  req_signed,
    input  req_addr,
    input  req_wdata,
    output resp_valid,
    input  resp_ready,
    output resp_data,
    output resp_fault,
    output mem_addr,
    output mem_wdata,
    output mem_write,
    output mem_read,
    input  mem_rdata
  );

  modport master (
    output req_valid,
    input  req_ready,
    output req_we,
    output req_byte,
    output req_hi,
    output req_signed,
    output req_addr,
    output req_wdata,
    input  resp_valid,
    output resp_ready,
    input  resp_data,
    input  resp_fault,
    input  mem_addr,
    input  mem_wdata,
    input  mem_write,
    input  mem_read,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_byte_align.sv
// Byte lane extract with sign/zero extension, and byte lane merge
// for read-modify-write stores.
module lsu_byte_align
  import ak16_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic              hi,
  input  logic              sgn,
  input  logic [7:0]        wbyte,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] merged
);

  logic [7:0] sel;

  always_comb begin
    sel    = hi ? word[15:8] : word[7:0];
    ext    = {{8{sgn & sel[7]}}, sel};
    merged = hi ? {wbyte, word[7:0]}
                : {word[15:8], wbyte};
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: sole dmem initiator, byte ops via RMW,
// out-of-range addresses fault without touching memory.
module lsu
  import ak16_pkg::*;
(
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_t        state;
  lsu_state_t        state_n;
  lsu_req_t          cap;
  lsu_req_t          cap_n;
  lsu_req_t          req_in;

  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_n;
  logic              fault_q;
  logic              fault_n;
  logic [ADDR_W-1:0] maddr_q;
  logic [ADDR_W-1:0] maddr_n;
  logic [DATA_W-1:0] mwdata_q;
  logic [DATA_W-1:0] mwdata_n;
  logic              mrd_q;
  logic              mrd_n;
  logic              mwr_q;
  logic              mwr_n;

  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] merged;

  assign req_in = '{
    we:    bus.req_we,
    byt:   bus.req_byte,
    hi:    bus.req_hi,
    sgn:   bus.req_signed & ~bus.req_we,
    wbyte: bus.req_wdata[7:0]
  };

  lsu_byte_align u_align (
    .word   (bus.mem_rdata),
    .hi     (cap.hi),
    .sgn    (cap.sgn),
    .wbyte  (cap.wbyte),
    .ext    (ext),
    .merged (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap      <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
    end else begin
      cap      <= cap_n;
      rdata_q  <= rdata_n;
      fault_q  <= fault_n;
      maddr_q  <= maddr_n;
      mwdata_q <= mwdata_n;
      mrd_q    <= mrd_n;
      mwr_q    <= mwr_n;
    end
  end

  // Strobes default low so each access is a single-cycle pulse.
  always_comb begin
    state_n  = state;
    cap_n    = cap;
    rdata_n  = rdata_q;
    fault_n  = fault_q;
    maddr_n  = maddr_q;
    mwdata_n = mwdata_q;
    mrd_n    = 1'b0;
    mwr_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cap_n   = req_in;
          rdata_n = '0;
          fault_n = 1'b0;
          if (addr_fault(bus.req_addr)) begin
            fault_n = 1'b1;
            state_n = RESP;
          end else if (bus.req_we && !bus.req_byte) begin
            maddr_n  = bus.req_addr;
            mwdata_n = bus.req_wdata;
            mwr_n    = 1'b1;
            state_n  = WR;
          end else begin
            maddr_n = bus.req_addr;
            mrd_n   = 1'b1;
            state_n = RD;
          end
        end
      end
      RD: begin
        state_n = cap.we ? MERGE : CAP;
      end
      CAP: begin
        rdata_n = cap.byt ? ext : bus.mem_rdata;
        state_n = RESP;
      end
      MERGE: begin
        mwdata_n = merged;
        mwr_n    = 1'b1;
        state_n  = WR;
      end
      WR: begin
        state_n = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          rdata_n = '0;
          fault_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = rdata_q;
  assign bus.resp_fault = fault_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;
  assign bus.mem_read   = mrd_q;
  assign bus.mem_write  = mwr_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: dmem model, arithmetic reference model,
// directed scenarios then randomized traffic.
module tb_lsu;
  import ak16_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus ();

  lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] dmem [256];
  logic [15:0] ref_mem [256];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          ready_mode = 0;
  bit          seen = 0;
  logic [15:0] held_d;
  logic        held_f;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)",
                  name, act, expv, $time);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_write) dmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_read) bus.mem_rdata <= dmem[bus.mem_addr[7:0]];
  end

  // Reference: operates on whole words with plain arithmetic.
  function automatic exp_t model(input logic we, input logic byt,
                                 input logic hi, input logic sgn,
                                 input logic [15:0] a,
                                 input logic [15:0] wd);
    exp_t e;
    int w, v, b;
    e.data = 16'h0;
    e.fault = 1'b0;
    e.acc = 0;
    if (int'(a) >= 256) begin
      e.fault = 1'b1;
      e.lat = 1;
    end else begin
      w = int'(ref_mem[a[7:0]]);
      b = int'(wd) % 256;
      if (we && !byt) begin
        ref_mem[a[7:0]] = wd;
        e.lat = 2;
      end else if (we) begin
        if (hi) v = (w % 256) + b * 256;
        else    v = (w / 256) * 256 + b;
        ref_mem[a[7:0]] = 16'(v);
        e.lat = 4;
      end else begin
        e.lat = 3;
        if (!byt) v = w;
        else begin
          v = hi ? (w / 256) : (w % 256);
          if (sgn && v >= 128) v = v - 256;
        end
        e.data = 16'(v);
      end
    end
    return e;
  endfunction

  // Monitor: pops on first response cycle, checks hold while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 0;
    end else if (bus.resp_valid) begin
      if (!seen) begin
        chk("resp_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("resp_data", 32'(bus.resp_data), 32'(e.data));
          chk("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
          chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
        held_d = bus.resp_data;
        held_f = bus.resp_fault;
        seen = 1;
      end else begin
        chk("resp_hold_data", 32'(bus.resp_data), 32'(held_d));
        chk("resp_hold_fault", 32'(bus.resp_fault), 32'(held_f));
      end
    end else begin
      seen = 0;
    end
    if (bus.mem_read || bus.mem_write) begin
      chk("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
      if (bus.mem_read) rd_cnt++;
      if (bus.mem_write) wr_cnt++;
    end
    if (ready_mode == 0) bus.resp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input logic we, input logic byt, input logic hi,
                       input logic sgn, input logic [15:0] a,
                       input logic [15:0] wd, input bit push,
                       input bit use_exp, input logic [15:0] xd);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.req_we = we;
    bus.req_byte = byt;
    bus.req_hi = hi;
    bus.req_signed = sgn;
    bus.req_addr = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    if (push) begin
      e = model(we, byt, hi, sgn, a, wd);
      if (use_exp) e.data = xd;
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(q.size() == 0 && bus.req_ready && !bus.resp_valid)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int r0, w0;
    logic [15:0] a, wd;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_byte = 1'b0;
    bus.req_hi = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 16'($urandom);
      ref_mem[i] = dmem[i];
    end

    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
    chk("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);

    // Word store then word load
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1, 0, 0, 0, 16'h0010, 16'hBEEF, 1, 0, 16'h0);
    wait_idle();
    chk("t1_store_writes", 32'(wr_cnt - w0), 32'd1);
    chk("t1_store_reads", 32'(rd_cnt - r0), 32'd0);
    r0 = rd_cnt; w0 = wr_cnt;
    issue(0, 0, 0, 0, 16'h0010, 16'h0, 1, 1, 16'hBEEF);
    wait_idle();
    chk("t1_load_reads", 32'(rd_cnt - r0), 32'd1);
    chk("t1_load_writes", 32'(wr_cnt - w0), 32'd0);

    // Byte loads with extension
    issue(1, 0, 0, 0, 16'h0020, 16'h12F0, 1, 0, 16'h0);
    issue(0, 1, 0, 1, 16'h0020, 16'h0, 1, 1, 16'hFFF0);
    issue(0, 1, 1, 0, 16'h0020, 16'h0, 1, 1, 16'h0012);
    issue(0, 1, 0, 0, 16'h0020, 16'h0, 1, 1, 16'h00F0);
    wait_idle();

    // Byte store RMW
    issue(1, 0, 0, 0, 16'h0030, 16'hAAAA, 1, 0, 16'h0);
    issue(1, 1, 1, 1, 16'h0030, 16'h3355, 1, 0, 16'h0);
    issue(0, 0, 0, 0, 16'h0030, 16'h0, 1, 1, 16'h55AA);
    issue(1, 1, 0, 0, 16'h0030, 16'h0077, 1, 0, 16'h0);
    issue(0, 0, 0, 0, 16'h0030, 16'h0, 1, 1, 16'h5577);
    wait_idle();

    // Fault: no memory access at all
    r0 = rd_cnt; w0 = wr_cnt;
    issue(0, 0, 0, 0, 16'h0100, 16'h0, 1, 0, 16'h0);
    issue(1, 0, 0, 0, 16'h8000, 16'h1234, 1, 0, 16'h0);
    wait_idle();
    chk("t4_no_reads", 32'(rd_cnt - r0), 32'd0);
    chk("t4_no_writes", 32'(wr_cnt - w0), 32'd0);
    issue(0, 0, 0, 0, 16'h0000, 16'h0, 1, 0, 16'h0);
    wait_idle();

    // Backpressure hold
    ready_mode = 1;
    bus.resp_ready = 1'b0;
    issue(0, 0, 0, 0, 16'h0010, 16'h0, 1, 1, 16'hBEEF);
    begin
      int n;
      n = 0;
      while (!bus.resp_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("t5_resp_seen", 32'(bus.resp_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_valid_held", 32'(bus.resp_valid), 32'd1);
      chk("t5_req_ready_low", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("t5_idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("t5_idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    ready_mode = 0;

    // Reset during MERGE of a byte store
    issue(1, 0, 0, 0, 16'h0040, 16'h1357, 1, 0, 16'h0);
    wait_idle();
    issue(1, 1, 1, 0, 16'h0040, 16'h00EE, 0, 0, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_mem_write", 32'(bus.mem_write), 32'd0);
    chk("t6_mem_read", 32'(bus.mem_read), 32'd0);
    chk("t6_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("t6_req_ready", 32'(bus.req_ready), 32'd1);
    w0 = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_no_write", 32'(wr_cnt - w0), 32'd0);
    issue(0, 0, 0, 0, 16'h0040, 16'h0, 1, 1, 16'h1357);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(256, 65535));
      else a = 16'($urandom_range(0, 15));
      wd = 16'($urandom);
      issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            a, wd, 1, 0, 16'h0);
    end
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      issue(0, 0, 0, 0, 16'(i), 16'h0, 1, 0, 16'h0);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
